// File: rtl/oflow_buffer_fsm_write_if.sv
// Core-to-buffer write handshake bundle for oflow_buffer_fsm_write.
// The core side (master) presents one group per ready pulse; the buffer
// side (slave) returns the memory-line write controls and frame status.
interface oflow_buffer_fsm_write_if #(
    parameter int ROW_LEN       = 4,
    parameter int PE_LEN        = 5,
    parameter int REMAINDER_LEN = 2,
    parameter int ADDR_W        = 8,
    parameter int BBOX_CNT_W    = 10
);
    logic                     start_write;
    logic                     ready_from_core;
    logic [ROW_LEN-1:0]       row_sel;
    logic [PE_LEN-1:0]        pe_sel;
    logic [REMAINDER_LEN-1:0] remainder;

    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [ROW_LEN-1:0]       row_out;
    logic [PE_LEN-1:0]        pe_idx;
    logic [1:0]               lane_valid;
    logic                     done_write_buffer;
    logic [BBOX_CNT_W-1:0]    bbox_count;
    logic                     overrun_err;

    modport master (
        output start_write, ready_from_core, row_sel, pe_sel, remainder,
        input  we, wr_addr, row_out, pe_idx, lane_valid,
               done_write_buffer, bbox_count, overrun_err
    );

    modport slave (
        input  start_write, ready_from_core, row_sel, pe_sel, remainder,
        output we, wr_addr, row_out, pe_idx, lane_valid,
               done_write_buffer, bbox_count, overrun_err
    );
endinterface

// File: rtl/oflow_buffer_fsm_write.sv
// Buffer-side write sequencer: each accepted core group becomes one or two
// memory-line writes holding two bboxes per line. Tracks the per-frame line
// address, a saturating bbox count and a sticky overrun flag.
module oflow_buffer_fsm_write #(
    parameter int PE_NUM        = 24,
    parameter int ROW_LEN       = 4,
    parameter int PE_LEN        = 5,
    parameter int REMAINDER_LEN = 2,
    parameter int ADDR_W        = 8,
    parameter int BBOX_CNT_W    = 10
) (
    input  logic                     clk,
    input  logic                     reset_N,
    oflow_buffer_fsm_write_if.slave  bus
);

    // Groups are 4 lanes wide and every lane index must fit in pe_idx.
    if ((PE_NUM % 4) != 0 || (PE_NUM - 1) >= (1 << PE_LEN)) begin : g_cfg_err
        $error("oflow_buffer_fsm_write: PE_NUM incompatible with PE_LEN");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [2:0]              n_reg;        // bboxes in the latched group, 1..4
    logic [PE_LEN-1:0]       base_reg;     // first lane of the latched group
    logic [ROW_LEN-1:0]      row_reg;
    logic                    we_reg;
    logic [PE_LEN-1:0]       pe_idx_reg;
    logic [1:0]              lane_valid_reg;
    logic                    done_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [BBOX_CNT_W-1:0]   count_reg;
    logic                    err_reg;

    logic [2:0]              n_next;
    logic [PE_LEN-1:0]       base_next;
    logic [BBOX_CNT_W:0]     count_sum;

    // Decode the incoming group size and base lane from the handshake fields.
    always_comb begin
        n_next    = (bus.remainder == '0) ? 3'd4 : 3'(bus.remainder);
        base_next = {bus.pe_sel[PE_LEN-3:0], 2'b00};
        count_sum = {1'b0, count_reg}
                  + (BBOX_CNT_W+1)'(lane_valid_reg[0])
                  + (BBOX_CNT_W+1)'(lane_valid_reg[1]);
    end

    // Write sequencer with registered line controls and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            state_reg      <= IDLE;
            n_reg          <= '0;
            base_reg       <= '0;
            row_reg        <= '0;
            we_reg         <= 1'b0;
            pe_idx_reg     <= '0;
            lane_valid_reg <= '0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            count_reg      <= '0;
            err_reg        <= 1'b0;
        end else if (bus.start_write) begin
            // Frame restart aborts any in-flight group without a done pulse.
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            lane_valid_reg <= '0;
            done_reg       <= 1'b0;
            addr_reg       <= '0;
            count_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            // Bookkeeping for the line being written this cycle.
            if (we_reg) begin
                addr_reg  <= addr_reg + ADDR_W'(1);
                count_reg <= count_sum[BBOX_CNT_W] ? '1 : count_sum[BBOX_CNT_W-1:0];
            end

            // A new group while one is still being written is a core protocol
            // violation: drop it and flag it.
            if (bus.ready_from_core && state_reg != IDLE) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (bus.ready_from_core) begin
                        state_reg      <= WR0;
                        n_reg          <= n_next;
                        base_reg       <= base_next;
                        row_reg        <= bus.row_sel;
                        we_reg         <= 1'b1;
                        pe_idx_reg     <= base_next;
                        lane_valid_reg <= (n_next >= 3'd2) ? 2'b11 : 2'b01;
                        done_reg       <= (n_next <= 3'd2);
                    end else begin
                        we_reg         <= 1'b0;
                        lane_valid_reg <= '0;
                        done_reg       <= 1'b0;
                    end
                end
                WR0: begin
                    if (n_reg > 3'd2) begin
                        state_reg      <= WR1;
                        we_reg         <= 1'b1;
                        pe_idx_reg     <= base_reg + PE_LEN'(2);
                        lane_valid_reg <= (n_reg == 3'd4) ? 2'b11 : 2'b01;
                        done_reg       <= 1'b1;
                    end else begin
                        state_reg      <= IDLE;
                        we_reg         <= 1'b0;
                        lane_valid_reg <= '0;
                        done_reg       <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    we_reg         <= 1'b0;
                    lane_valid_reg <= '0;
                    done_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.we                = we_reg;
    assign bus.wr_addr           = addr_reg;
    assign bus.row_out           = row_reg;
    assign bus.pe_idx            = pe_idx_reg;
    assign bus.lane_valid        = lane_valid_reg;
    assign bus.done_write_buffer = done_reg;
    assign bus.bbox_count        = count_reg;
    assign bus.overrun_err       = err_reg;

endmodule
